// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment scroller.
//   - SEG_* : active-low segment codes, bit order g..a (bit 6 = g, bit 0 = a)
//   - state_t : controller states
//   - bcd_t : one BCD digit
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STATIC = 2'd1,
    SCROLL = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD digit to active-low seven-segment code.
//   digit_i : BCD digit; values above 9 render as a dash
//   blank_i : forces all segments off
//   seg_o   : segments g..a, active-low
module seg7_decode
  import seg7_pkg::*;
(
  input  bcd_t       digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_hex_scroller.sv
// bcd_hex_scroller: shows a latched BCD number on the eight DE2 displays,
// right-aligned; numbers wider than the display scroll through an
// eight-digit window, one step every SCROLL_DIV clocks.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : digits_flat / num_digits valid
//   in_ready     : a new number can be accepted
//   digits_flat  : N_DIG BCD digits, digit 0 least significant
//   num_digits   : significant digit count (0 treated as 1)
//   hex_flat     : HEXk at [7k+:7], g..a, active-low, registered
//   scrolling    : high in SCROLL
// Build option: define LEADING_ZERO_EN to show '0' instead of blank on the
// unused positions of a short (non-scrolling) number.
//
// state  | meaning
// IDLE   | nothing latched, all blank
// STATIC | number fits, shown right-aligned
// SCROLL | window sweeps from the top digits down to digit 0, then repeats
module bcd_hex_scroller
  import seg7_pkg::*;
#(
  parameter int N_DIG      = 10,
  parameter int N_DISP     = 8,
  parameter int SCROLL_DIV = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*N_DIG-1:0]    digits_flat,
  input  logic [3:0]            num_digits,
  output logic [7*N_DISP-1:0]   hex_flat,
  output logic                  scrolling
);

  localparam int CW = $clog2(SCROLL_DIV);
  localparam int OW = (N_DIG - N_DISP + 1 > 2) ? $clog2(N_DIG - N_DISP + 1) : 1;
  localparam int IW = 4;
  localparam logic [CW-1:0] CNT_TC = CW'(SCROLL_DIV - 1);

  state_t              state_q, state_d;
  logic [4*N_DIG-1:0]  digits_q, digits_d;
  logic [3:0]          n_q, n_d;
  logic [OW-1:0]       off_q, off_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                swept_q, swept_d;
  logic [7*N_DISP-1:0] hex_q, hex_d;

  logic                accept;
  logic [3:0]          n_in;
  bcd_t                dig_d [N_DIG];

  assign in_ready  = (state_q != SCROLL) || swept_q;
  assign scrolling = (state_q == SCROLL);
  assign hex_flat  = hex_q;

  always_comb begin
    accept   = in_valid && in_ready;
    n_in     = (num_digits == 4'd0)        ? 4'd1 :
               (num_digits > 4'(N_DIG))    ? 4'(N_DIG) : num_digits;
    state_d  = state_q;
    digits_d = digits_q;
    n_d      = n_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    swept_d  = swept_q;

    if (accept) begin
      digits_d = digits_flat;
      n_d      = n_in;
      cnt_d    = '0;
      swept_d  = 1'b0;
      if (n_in > 4'(N_DISP)) begin
        state_d = SCROLL;
        off_d   = OW'(n_in - 4'(N_DISP));
      end else begin
        state_d = STATIC;
        off_d   = '0;
      end
    end else if (state_q == SCROLL) begin
      if (cnt_q == CNT_TC) begin
        cnt_d = '0;
        // Offset 0 has been on screen for a full tick: the sweep is done,
        // return to the most significant window.
        if (off_q == '0) begin
          off_d   = OW'(n_q - 4'(N_DISP));
          swept_d = 1'b1;
        end else begin
          off_d = off_q - 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Display contents are decoded from next-state values so hex_flat
  // changes on the same edge as the accept or the scroll step.
  for (genvar i = 0; i < N_DIG; i++) begin : g_dig
    assign dig_d[i] = digits_d[4*i +: 4];
  end

  for (genvar k = 0; k < N_DISP; k++) begin : g_disp
    bcd_t          dig;
    logic          blank;
    logic [IW-1:0] idx;

    always_comb begin
      idx   = IW'(off_d) + IW'(k);
      dig   = '0;
      blank = 1'b1;
      case (state_d)
        STATIC: begin
          if (4'(k) < n_d) begin
            dig   = dig_d[k];
            blank = 1'b0;
          end else begin
`ifdef LEADING_ZERO_EN
            dig   = '0;
            blank = 1'b0;
`else
            blank = 1'b1;
`endif
          end
        end
        SCROLL: begin
          dig   = dig_d[idx];
          blank = 1'b0;
        end
        default: ;
      endcase
    end

    seg7_decode u_dec (
      .digit_i (dig),
      .blank_i (blank),
      .seg_o   (hex_d[7*k +: 7])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      digits_q <= '0;
      n_q      <= '0;
      off_q    <= '0;
      cnt_q    <= '0;
      swept_q  <= 1'b0;
      hex_q    <= '1;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      n_q      <= n_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      swept_q  <= swept_d;
      hex_q    <= hex_d;
    end
  end

endmodule
